// File: rtl/aclk_fsm.sv
// Alarm clock mode controller: decodes buttons and keypad into load/shift strobes and display selects.
// Latency: Moore outputs straight off the state register. Backpressure: none; inputs are sampled every cycle.
module aclk_fsm #(
  parameter logic [3:0]  NOKEY     = 4'd10,
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [3:0] key,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift,
  output logic       reset_count
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_S - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_vld;
  logic             timeout;
  logic             counting_q;
  logic             counting_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_vld = (key != NOKEY);
  assign timeout = one_second && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button)  state_d = SHOW_ALARM;
        else if (key_vld)  state_d = KEY_STORED;
      end
      KEY_STORED:          state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_vld)      state_d = KEY_ENTRY;
        else if (timeout)  state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)      state_d = SET_ALARM_TIME;
        else if (time_button)  state_d = SET_CURRENT_TIME;
        else if (key_vld)      state_d = KEY_STORED;
        else if (timeout)      state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:      state_d = SHOW_TIME;
      SET_CURRENT_TIME:    state_d = SHOW_TIME;
      default:             state_d = SHOW_TIME;
    endcase
  end

  // The count only survives while staying inside the waited/entry pair, so a new key
  // (through KEY_STORED) or any exit restarts it from zero.
  assign counting_q = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
  assign counting_d = (state_d == KEY_WAITED) || (state_d == KEY_ENTRY);

  always_comb begin
    cnt_d = '0;
    if (counting_q && counting_d) begin
      // Saturate: a key release that coincides with the final tick keeps the entry alive,
      // and the next tick must still time it out.
      if (one_second && (cnt_q != CNT_LAST)) cnt_d = cnt_q + 1'b1;
      else                                   cnt_d = cnt_q;
    end
  end

  always_comb begin
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    show_a        = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    reset_count   = 1'b0;
    case (state_q)
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED:  show_new_time = 1'b1;
      KEY_ENTRY:   show_new_time = 1'b1;
      SHOW_ALARM:  show_a        = 1'b1;
      SET_ALARM_TIME: begin
        load_new_a = 1'b1;
        show_a     = 1'b1;
      end
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aclk_fsm.sv
// Bench for aclk_fsm: vector table plus hand sequences, expectations queued at drive time.
module tb_aclk_fsm;

  localparam logic [3:0] NK = 4'd10;
  // {load_new_a, load_new_c, show_a, show_new_time, shift, reset_count}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_STO  = 6'b000110;
  localparam logic [5:0] O_NT   = 6'b000100;
  localparam logic [5:0] O_SA   = 6'b001000;
  localparam logic [5:0] O_SETA = 6'b101000;
  localparam logic [5:0] O_SETC = 6'b010001;

  logic       clock = 1'b0;
  logic       reset, one_second, alarm_button, time_button;
  logic [3:0] key;
  logic       load_new_a, load_new_c, show_a, show_new_time, shift, reset_count;
  logic [5:0] outs;

  typedef struct {
    logic       rst;
    logic       os;
    logic       ab;
    logic       tb;
    logic [3:0] k;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb_q[$];
  string      nm_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         shift_cnt = 0;

  always #5 clock = ~clock;

  aclk_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .key          (key),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .show_a       (show_a),
    .show_new_time(show_new_time),
    .shift        (shift),
    .reset_count  (reset_count)
  );

  assign outs = {load_new_a, load_new_c, show_a, show_new_time, shift, reset_count};

  task automatic step(input logic rst, input logic os, input logic ab, input logic tb,
                      input logic [3:0] k, input logic [5:0] exp, input string nm);
    logic [5:0] e;
    string      n;
    @(negedge clock);
    reset = rst; one_second = os; alarm_button = ab; time_button = tb; key = k;
    sb_q.push_back(exp);
    nm_q.push_back(nm);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    n = nm_q.pop_front();
    n_tests++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL %s: outputs %b, required %b", n, outs, e);
    end
    n_tests++;
    if (show_a === 1'b1 && show_new_time === 1'b1) begin
      n_fail++;
      $display("FAIL %s_excl: show_a=%b show_new_time=%b, required not both 1", n, show_a, show_new_time);
    end
    if (shift === 1'b1) shift_cnt++;
  endtask

  task automatic add(input logic rst, input logic os, input logic ab, input logic tb,
                     input logic [3:0] k, input logic [5:0] exp, input string nm);
    vec_t v;
    v.rst = rst; v.os = os; v.ab = ab; v.tb = tb; v.k = k; v.exp = exp; v.name = nm;
    vecs.push_back(v);
  endtask

  // n one-cycle ticks, each followed by a quiet cycle, with key held at k
  task automatic ticks(input int n, input logic [3:0] k, input string nm);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, k, O_NT, nm);
      step(0, 0, 0, 0, k, O_NT, nm);
    end
  endtask

  task automatic check_shifts(input int want, input string nm);
    n_tests++;
    if (shift_cnt != want) begin
      n_fail++;
      $display("FAIL %s: shift pulses %0d, required %0d", nm, shift_cnt, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; one_second = 1'b0; alarm_button = 1'b0; time_button = 1'b0; key = NK;

    add(1, 0, 1, 0, 4'd5, O_IDLE, "rst_hold0");
    add(1, 0, 1, 0, 4'd5, O_IDLE, "rst_hold1");
    add(0, 0, 1, 0, 4'd5, O_SA,   "rst_exit_alarm");
    add(0, 0, 0, 0, NK,   O_IDLE, "alarm_release");
    add(0, 0, 0, 0, 4'd7, O_STO,  "aset_key");
    add(0, 0, 0, 0, NK,   O_NT,   "aset_wait");
    add(0, 0, 0, 0, NK,   O_NT,   "aset_entry");
    add(0, 0, 1, 1, NK,   O_SETA, "aset_both_btn");
    add(0, 0, 0, 0, NK,   O_IDLE, "aset_done");
    add(0, 0, 0, 0, 4'd8, O_STO,  "btnkey_key");
    add(0, 0, 0, 0, NK,   O_NT,   "btnkey_wait");
    add(0, 0, 0, 0, NK,   O_NT,   "btnkey_entry");
    add(0, 0, 0, 1, 4'd9, O_SETC, "btn_beats_key");
    add(0, 0, 0, 0, NK,   O_IDLE, "btnkey_done");
    add(0, 0, 0, 0, 4'd3, O_STO,  "rstmid_key");
    add(0, 0, 0, 0, NK,   O_NT,   "rstmid_wait");
    add(1, 0, 0, 1, NK,   O_IDLE, "rst_mid_entry");
    add(0, 0, 0, 0, NK,   O_IDLE, "rstmid_after");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].os, vecs[i].ab, vecs[i].tb, vecs[i].k, vecs[i].exp, vecs[i].name);

    // four-digit entry then time set
    shift_cnt = 0;
    for (int d = 1; d <= 4; d++) begin
      step(0, 0, 0, 0, 4'(d), O_STO, "entry_shift");
      step(0, 0, 0, 0, 4'(d), O_NT,  "entry_held");
      step(0, 0, 0, 0, 4'(d), O_NT,  "entry_held");
      step(0, 0, 0, 0, NK,    O_NT,  "entry_gap");
      step(0, 0, 0, 0, NK,    O_NT,  "entry_gap");
    end
    step(0, 0, 0, 1, NK, O_SETC, "entry_set_time");
    step(0, 0, 0, 0, NK, O_IDLE, "entry_done");
    check_shifts(4, "entry_shift_count");

    // alarm display ignores keys
    shift_cnt = 0;
    for (int i = 0; i < 20; i++)
      step(0, 0, 1, 0, (i >= 5 && i < 10) ? 4'd3 : NK, O_SA, "show_alarm");
    step(0, 0, 0, 0, NK, O_IDLE, "show_alarm_release");
    check_shifts(0, "show_alarm_no_shift");

    // timeout after 10 ticks
    step(0, 0, 0, 0, 4'd5, O_STO, "to_key");
    step(0, 0, 0, 0, NK,   O_NT,  "to_wait");
    step(0, 0, 0, 0, NK,   O_NT,  "to_entry");
    ticks(9, NK, "to_tick");
    step(0, 1, 0, 0, NK, O_IDLE, "to_exit_10th");
    step(0, 0, 0, 0, NK, O_IDLE, "to_after");

    // key after 9th tick restarts the count
    step(0, 0, 0, 0, 4'd5, O_STO, "rs_key");
    step(0, 0, 0, 0, NK,   O_NT,  "rs_wait");
    step(0, 0, 0, 0, NK,   O_NT,  "rs_entry");
    ticks(9, NK, "rs_tick");
    step(0, 0, 0, 0, 4'd6, O_STO, "rs_key2");
    step(0, 0, 0, 0, NK,   O_NT,  "rs_wait2");
    step(0, 0, 0, 0, NK,   O_NT,  "rs_entry2");
    ticks(9, NK, "rs_tick2");
    step(0, 1, 0, 0, NK, O_IDLE, "rs_exit");

    // key coinciding with the final tick wins, and the count restarts
    step(0, 0, 0, 0, 4'd1, O_STO, "kt_key");
    step(0, 0, 0, 0, NK,   O_NT,  "kt_wait");
    step(0, 0, 0, 0, NK,   O_NT,  "kt_entry");
    ticks(9, NK, "kt_tick");
    step(0, 1, 0, 0, 4'd2, O_STO, "key_beats_timeout");
    step(0, 0, 0, 0, NK,   O_NT,  "kt_wait2");
    step(0, 0, 0, 0, NK,   O_NT,  "kt_entry2");
    ticks(9, NK, "kt_tick2");
    step(0, 1, 0, 0, NK, O_IDLE, "kt_exit");

    // held key: stored once, times out from KEY_WAITED
    shift_cnt = 0;
    step(0, 0, 0, 0, 4'd4, O_STO, "held_key");
    step(0, 0, 0, 0, 4'd4, O_NT,  "held_wait");
    ticks(9, 4'd4, "held_tick");
    step(0, 1, 0, 0, 4'd4, O_IDLE, "held_exit_10th");
    step(0, 0, 0, 0, NK,   O_IDLE, "held_after");
    check_shifts(1, "held_single_shift");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
